// File: rtl/mem_ctrl_if.sv
// Bundle of host-side and common-bus signals for mem_ctrl.
// master: the environment (host + common bus); slave: the controller.
interface mem_ctrl_if #(
   parameter int ADDR_BITCOUNT = 64,
   parameter int WORD_SIZE     = 32,
   parameter int CL_SIZE_WIDTH = 512
) ();

   logic                     host_init;
   logic                     host_rd_ready;
   logic                     host_wr_ready;
   logic [1:0]               op;
   logic [ADDR_BITCOUNT-1:0] raw_address;
   logic [ADDR_BITCOUNT-1:0] address_offset;
   logic [WORD_SIZE-1:0]     common_data_bus_read_in;
   logic [WORD_SIZE-1:0]     common_data_bus_write_out;
   logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in;
   logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out;
   logic [ADDR_BITCOUNT-1:0] corrected_address;
   logic                     ready;
   logic                     tx_done;
   logic                     rd_valid;
   logic                     host_re;
   logic                     host_we;

   modport master (
      output host_init,
      output host_rd_ready,
      output host_wr_ready,
      output op,
      output raw_address,
      output address_offset,
      output common_data_bus_read_in,
      output host_data_bus_read_in,
      input  common_data_bus_write_out,
      input  host_data_bus_write_out,
      input  corrected_address,
      input  ready,
      input  tx_done,
      input  rd_valid,
      input  host_re,
      input  host_we
   );

   modport slave (
      input  host_init,
      input  host_rd_ready,
      input  host_wr_ready,
      input  op,
      input  raw_address,
      input  address_offset,
      input  common_data_bus_read_in,
      input  host_data_bus_read_in,
      output common_data_bus_write_out,
      output host_data_bus_write_out,
      output corrected_address,
      output ready,
      output tx_done,
      output rd_valid,
      output host_re,
      output host_we
   );

endinterface

// File: rtl/mem_ctrl.sv
// Cache-line <-> word-serial bridge.
// Reads pop one line from the host and stream it out lowest word first;
// writes gather WORDS bus words into a line and hand it to the host.
//
// state   | meaning
// --------+-----------------------------------------------------------
// STARTUP | after reset, waiting for host_init
// READY   | idle, ready=1, op sampled here only
// RD_REQ  | waiting for host_rd_ready, host_re mirrors it
// FILL_RD | streaming line_buffer out one word per cycle (rd_valid=1)
// FILL_WR | capturing one bus word per cycle into line_buffer
// WR_REQ  | line presented to host, waiting for host_wr_ready
module mem_ctrl #(
   parameter int ADDR_BITCOUNT = 64,
   parameter int WORD_SIZE     = 32,
   parameter int CL_SIZE_WIDTH = 512
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   localparam int WORDS = CL_SIZE_WIDTH / WORD_SIZE;
   localparam int CNT_W = $clog2(WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b11;

   localparam logic [2:0] STARTUP = 3'd0;
   localparam logic [2:0] READY   = 3'd1;
   localparam logic [2:0] RD_REQ  = 3'd2;
   localparam logic [2:0] FILL_RD = 3'd3;
   localparam logic [2:0] FILL_WR = 3'd4;
   localparam logic [2:0] WR_REQ  = 3'd5;

   logic [2:0]               state;
   logic [2:0]               state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic [CL_SIZE_WIDTH-1:0] line_buffer;
   logic [WORD_SIZE-1:0]     cur_word;
   logic                     last_word;

   assign last_word = (cnt == CNT_LAST);
   assign cur_word  = line_buffer[int'(cnt) * WORD_SIZE +: WORD_SIZE];

   // Carry out of the top bit is intentionally dropped (mod 2^ADDR_BITCOUNT).
   assign bus.corrected_address = bus.raw_address + bus.address_offset;

   // Next-state decode; the read/write mode lives in which FILL state is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         STARTUP: if (bus.host_init) state_nxt = READY;
         READY: begin
            if (bus.op == OP_READ)       state_nxt = RD_REQ;
            else if (bus.op == OP_WRITE) state_nxt = FILL_WR;
         end
         RD_REQ:  if (bus.host_rd_ready) state_nxt = FILL_RD;
         FILL_RD: if (last_word)         state_nxt = READY;
         FILL_WR: if (last_word)         state_nxt = WR_REQ;
         WR_REQ:  if (bus.host_wr_ready) state_nxt = READY;
         default:                        state_nxt = STARTUP;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= STARTUP;
      else     state <= state_nxt;
   end

   // Word counter: cleared on entry to either FILL state, advances while filling.
   // It wraps back to zero naturally after the last word.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case (state)
            FILL_RD, FILL_WR: cnt <= cnt + 1'b1;
            default:          cnt <= '0;
         endcase
      end
   end

   // Line buffer: loaded whole from the host on a read, word by word on a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_buffer <= '0;
      end else if (state == RD_REQ && bus.host_rd_ready) begin
         line_buffer <= bus.host_data_bus_read_in;
      end else if (state == FILL_WR) begin
         line_buffer[int'(cnt) * WORD_SIZE +: WORD_SIZE] <= bus.common_data_bus_read_in;
      end
   end

   // Outputs are pure decodes of state so reset forces every strobe low.
   assign bus.ready                     = (state == READY);
   assign bus.host_re                   = (state == RD_REQ) && bus.host_rd_ready;
   assign bus.host_we                   = (state == WR_REQ) && bus.host_wr_ready;
   assign bus.rd_valid                  = (state == FILL_RD);
   assign bus.common_data_bus_write_out = (state == FILL_RD) ? cur_word : '0;
   assign bus.host_data_bus_write_out   = line_buffer;
   assign bus.tx_done                   = ((state == FILL_RD) && last_word) ||
                                          ((state == WR_REQ) && bus.host_wr_ready);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset, read stream, stalled read, write gather,
// address arithmetic and reset abort.
module tb_mem_ctrl;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   mem_ctrl_if bus ();

   mem_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one posedge and settle before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [511:0] line_a;
   logic [511:0] line_b;
   logic [511:0] line_w;

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 16; i++) begin
         line_a[i*32 +: 32] = 32'(i);
         line_b[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
         line_w[i*32 +: 32] = 32'hA0 + 32'(i);
      end

      rst                         = 1'b1;
      bus.host_init               = 1'b0;
      bus.host_rd_ready           = 1'b0;
      bus.host_wr_ready           = 1'b0;
      bus.op                      = 2'b00;
      bus.raw_address             = '0;
      bus.address_offset          = '0;
      bus.common_data_bus_read_in = '0;
      bus.host_data_bus_read_in   = '0;

      // Reset
      repeat (5) tick();
      chk("rst_ready",    bus.ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_tx_done",  bus.tx_done, 0);
      chk("rst_host_re",  bus.host_re, 0);
      chk("rst_host_we",  bus.host_we, 0);
      chk("rst_cdb_out",  bus.common_data_bus_write_out, 0);
      chk("rst_host_out", bus.host_data_bus_write_out, 0);

      rst = 1'b0;
      bus.host_init = 1'b1;
      tick();
      chk("startup_ready", bus.ready, 1);

      // Read: addresses, handshake, 16-word stream
      bus.raw_address    = 64'h10;
      bus.address_offset = 64'h20;
      bus.host_data_bus_read_in = line_a;
      bus.host_rd_ready  = 1'b1;
      bus.op             = 2'b01;
      #1;
      chk("addr_sum", bus.corrected_address, 64'h30);
      chk("ready_no_re", bus.host_re, 0);
      tick();
      bus.op = 2'b00;
      chk("rdreq_host_re", bus.host_re, 1);
      chk("rdreq_ready",   bus.ready, 0);
      chk("rdreq_rdv",     bus.rd_valid, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("rd_word%0d", i), bus.common_data_bus_write_out, 32'(i));
         chk($sformatf("rd_valid%0d", i), bus.rd_valid, 1);
         chk($sformatf("rd_done%0d", i), bus.tx_done, (i == 15) ? 1 : 0);
         tick();
      end
      chk("rd_end_ready",  bus.ready, 1);
      chk("rd_end_rdv",    bus.rd_valid, 0);
      chk("rd_end_cdb",    bus.common_data_bus_write_out, 0);
      chk("rd_end_done",   bus.tx_done, 0);

      // Reserved op is idle
      bus.op = 2'b10;
      tick();
      chk("op10_ready", bus.ready, 1);
      chk("op10_re",    bus.host_re, 0);

      // Write: gather 0xA0..0xAF, op change mid-fill ignored
      bus.host_rd_ready = 1'b0;
      bus.op = 2'b11;
      tick();
      bus.op = 2'b00;
      for (int i = 0; i < 16; i++) begin
         bus.common_data_bus_read_in = 32'hA0 + 32'(i);
         if (i == 5) bus.op = 2'b01;
         #1;
         chk($sformatf("wr_ready%0d", i), bus.ready, 0);
         chk($sformatf("wr_rdv%0d", i), bus.rd_valid, 0);
         tick();
      end
      bus.op = 2'b00;
      chk("wrreq_we",    bus.host_we, 0);
      chk("wrreq_done",  bus.tx_done, 0);
      chk("wrreq_re",    bus.host_re, 0);
      tick();
      chk("wrreq_hold_we", bus.host_we, 0);
      bus.host_wr_ready = 1'b1;
      #1;
      chk("wr_we",   bus.host_we, 1);
      chk("wr_done", bus.tx_done, 1);
      chk("wr_line", bus.host_data_bus_write_out, line_w);
      tick();
      bus.host_wr_ready = 1'b0;
      chk("wr_end_ready", bus.ready, 1);
      chk("wr_end_done",  bus.tx_done, 0);

      // Address arithmetic
      bus.raw_address    = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.address_offset = 64'h2;
      #1;
      chk("addr_wrap", bus.corrected_address, 64'h1);
      bus.raw_address    = 64'h1234_5678_9ABC_DEF0;
      bus.address_offset = 64'h1111_1111_1111_1111;
      #1;
      chk("addr_mix", bus.corrected_address, 64'h2345_6789_ABCD_F001);

      // Stalled read, then reset at cnt=7
      bus.host_data_bus_read_in = line_b;
      bus.op = 2'b01;
      tick();
      bus.op = 2'b00;
      repeat (3) begin
         chk("stall_re",  bus.host_re, 0);
         chk("stall_rdv", bus.rd_valid, 0);
         tick();
      end
      bus.host_rd_ready = 1'b1;
      #1;
      chk("stall_re_go", bus.host_re, 1);
      tick();
      bus.host_rd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rb_word%0d", i), bus.common_data_bus_write_out, 32'hC0DE_0000 + 32'(i));
         if (i < 7) tick();
      end
      rst = 1'b1;
      tick();
      chk("abort_rdv",   bus.rd_valid, 0);
      chk("abort_ready", bus.ready, 0);
      chk("abort_cdb",   bus.common_data_bus_write_out, 0);
      chk("abort_line",  bus.host_data_bus_write_out, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("abort_done%0d", i), bus.tx_done, 0);
         chk($sformatf("abort_re%0d", i), bus.host_re, 0);
         tick();
      end
      chk("abort_back_ready", bus.ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
